// File: rtl/ysyx_22050058_mem_arbiter_pkg.sv
// Shared definitions for the fetch/LSU memory arbiter.
// Holds the FSM state encoding, the requester identity used by the
// round-robin last-grant register, and the latched access-kind constants.
// Optional feature macro (used by the top): YSYX_22050058_ARB_RR_EN.
package ysyx_22050058_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_WAIT  = 2'd1,
    ST_LSU_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  // Last-grant value after reset: pretending fetch went last hands LSU priority.
  localparam arb_owner_e LAST_GNT_RST = OWN_IF;

  // Latched access kind of the in-flight LSU transaction (we==0 -> read).
  localparam logic ACC_READ  = 1'b0;
  localparam logic ACC_WRITE = 1'b1;

endpackage

// File: rtl/ysyx_22050058_mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch, LSU), the arbiter and the
// single shared memory port. Signal names match the original flat port list.
//   slave  : arbiter side (requests and memory responses in; grants,
//            responses and memory command out)
//   master : environment side (requesters + memory), directions reversed
interface ysyx_22050058_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned MASK_W = DATA_W / 8;

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              lsu_req_i;
  logic [MASK_W-1:0] lsu_we_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [DATA_W-1:0] lsu_wdata_i;
  logic              lsu_gnt_o;
  logic              lsu_rvalid_o;
  logic              lsu_wdone_o;
  logic [DATA_W-1:0] lsu_rdata_o;

  logic              mem_ce_o;
  logic              mem_re_o;
  logic [MASK_W-1:0] mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_rvalid_i;
  logic              mem_wvalid_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_wdone_o, lsu_rdata_o,
    output mem_ce_o, mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_rvalid_i, mem_wvalid_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_wdone_o, lsu_rdata_o,
    input  mem_ce_o, mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_rvalid_i, mem_wvalid_i
  );
endinterface

// File: rtl/ysyx_22050058_mem_arbiter_arb_pick.sv
// Combinational 2-way selector between LSU and fetch.
// Ports: lsu_req/if_req requests, prio_lsu (1: LSU wins a tie, 0: fetch wins),
//        pick_lsu/pick_if one-hot (or zero) winner.
module ysyx_22050058_arb_pick (
  input  logic lsu_req,
  input  logic if_req,
  input  logic prio_lsu,
  output logic pick_lsu,
  output logic pick_if
);
  always_comb begin
    pick_lsu = lsu_req && (prio_lsu || !if_req);
    pick_if  = if_req && !pick_lsu;
  end
endmodule

// File: rtl/ysyx_22050058_mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch (read-only) and
// the LSU (byte-masked read/write). At most one transaction is outstanding:
// a command is issued combinationally in IDLE, then the owner waits for the
// memory response (one cycle later) before the port is free again.
// Ports: clk, rst (async, active-high; all outputs forced to 0 while high),
//        bus (ysyx_22050058_mem_arbiter_if.slave) carrying every request,
//        response and memory signal.
// Option: define YSYX_22050058_ARB_RR_EN for round-robin arbitration with a
//         1-bit last-grant register; otherwise fixed LSU-first priority.
module ysyx_22050058_mem_arbiter
  import ysyx_22050058_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_22050058_mem_arbiter_if.slave bus
);
  localparam int unsigned MASK_W = DATA_W / 8;

  arb_state_e state_q, state_nx;
  logic       acc_q;
  logic       prio_lsu;
  logic       pick_lsu, pick_if;

  logic              if_gnt_c, if_rvalid_c, lsu_gnt_c, lsu_rvalid_c, lsu_wdone_c;
  logic              mem_ce_c, mem_re_c;
  logic [MASK_W-1:0] mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c, if_rdata_c, lsu_rdata_c;

  ysyx_22050058_arb_pick u_pick (
    .lsu_req  (bus.lsu_req_i),
    .if_req   (bus.if_req_i),
    .prio_lsu (prio_lsu),
    .pick_lsu (pick_lsu),
    .pick_if  (pick_if)
  );

`ifdef YSYX_22050058_ARB_RR_EN
  arb_owner_e last_gnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= LAST_GNT_RST;
    end else if (lsu_gnt_c) begin
      last_gnt_q <= OWN_LSU;
    end else if (if_gnt_c) begin
      last_gnt_q <= OWN_IF;
    end
  end

  assign prio_lsu = (last_gnt_q == OWN_IF);
`else
  assign prio_lsu = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= ACC_READ;
    end else begin
      state_q <= state_nx;
      if (lsu_gnt_c) begin
        acc_q <= (|bus.lsu_we_i) ? ACC_WRITE : ACC_READ;
      end
    end
  end

  always_comb begin
    state_nx     = state_q;
    mem_ce_c     = 1'b1;
    mem_re_c     = 1'b0;
    mem_we_c     = '0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    if_gnt_c     = 1'b0;
    if_rvalid_c  = 1'b0;
    if_rdata_c   = '0;
    lsu_gnt_c    = 1'b0;
    lsu_rvalid_c = 1'b0;
    lsu_wdone_c  = 1'b0;
    lsu_rdata_c  = '0;
    unique case (state_q)
      ST_IDLE: begin
        // Stray memory valids are deliberately not looked at here.
        if (pick_lsu) begin
          lsu_gnt_c   = 1'b1;
          mem_re_c    = ~|bus.lsu_we_i;
          mem_we_c    = bus.lsu_we_i;
          mem_addr_c  = bus.lsu_addr_i;
          mem_wdata_c = bus.lsu_wdata_i;
          state_nx    = ST_LSU_WAIT;
        end else if (pick_if) begin
          if_gnt_c   = 1'b1;
          mem_re_c   = 1'b1;
          mem_addr_c = bus.if_addr_i;
          state_nx   = ST_IF_WAIT;
        end
      end
      ST_IF_WAIT: begin
        if_rvalid_c = bus.mem_rvalid_i;
        if (bus.mem_rvalid_i) begin
          if_rdata_c = bus.mem_rdata_i;
          state_nx   = ST_IDLE;
        end
      end
      ST_LSU_WAIT: begin
        if (acc_q == ACC_WRITE) begin
          lsu_wdone_c = bus.mem_wvalid_i;
          if (bus.mem_wvalid_i) state_nx = ST_IDLE;
        end else begin
          lsu_rvalid_c = bus.mem_rvalid_i;
          if (bus.mem_rvalid_i) begin
            lsu_rdata_c = bus.mem_rdata_i;
            state_nx    = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Reset forces every output low at once, including chip enable.
  assign bus.mem_ce_o     = mem_ce_c & ~rst;
  assign bus.mem_re_o     = mem_re_c & ~rst;
  assign bus.mem_we_o     = rst ? '0 : mem_we_c;
  assign bus.mem_addr_o   = rst ? '0 : mem_addr_c;
  assign bus.mem_wdata_o  = rst ? '0 : mem_wdata_c;
  assign bus.if_gnt_o     = if_gnt_c & ~rst;
  assign bus.if_rvalid_o  = if_rvalid_c & ~rst;
  assign bus.if_rdata_o   = rst ? '0 : if_rdata_c;
  assign bus.lsu_gnt_o    = lsu_gnt_c & ~rst;
  assign bus.lsu_rvalid_o = lsu_rvalid_c & ~rst;
  assign bus.lsu_wdone_o  = lsu_wdone_c & ~rst;
  assign bus.lsu_rdata_o  = rst ? '0 : lsu_rdata_c;

endmodule

// File: doc/ysyx_22050058_mem_arbiter.md
YSYX_22050058_MEM_ARBITER -- requirements
Module: ysyx_22050058_mem_arbiter

Interface
REQ-001 SHALL declare parameter ADDR_W, default 64, memory address width.
REQ-002 SHALL declare parameter DATA_W, default 64, memory data width; mask width = DATA_W/8.
REQ-003 SHALL have clk  input  1  single clock, all state on posedge.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have if_req_i  input  1, if_addr_i  input  ADDR_W: fetch read request (read-only requester).
REQ-006 SHALL have if_gnt_o  output  1, if_rvalid_o  output  1, if_rdata_o  output  DATA_W: fetch accept pulse, response valid, response data.
REQ-007 SHALL have lsu_req_i  input  1, lsu_we_i  input  DATA_W/8, lsu_addr_i  input  ADDR_W, lsu_wdata_i  input  DATA_W: LSU request; we==0 means read, otherwise byte-masked write.
REQ-008 SHALL have lsu_gnt_o  output  1, lsu_rvalid_o  output  1, lsu_wdone_o  output  1, lsu_rdata_o  output  DATA_W: LSU accept, read response, write completion, read data.
REQ-009 SHALL have mem_ce_o  output  1, mem_re_o  output  1, mem_we_o  output  DATA_W/8, mem_addr_o  output  ADDR_W, mem_wdata_o  output  DATA_W: single shared memory port.
REQ-010 SHALL have mem_rdata_i  input  DATA_W, mem_rvalid_i  input  1, mem_wvalid_i  input  1: memory responses, one cycle after the command.

Function
REQ-011 SHALL implement FSM IDLE, IF_WAIT, LSU_WAIT; at most one outstanding memory transaction.
REQ-012 SHALL, in IDLE with a pending request, drive the winner's command on mem_* combinationally, assert its gnt_o for exactly that cycle, and move to the matching WAIT state.
REQ-013 SHALL, in IDLE with no request, drive mem_ce_o=1, mem_re_o=0, mem_we_o=0, addr/wdata=0.
REQ-014 SHALL, in any WAIT state, drive mem_re_o=0 and mem_we_o=0 (no new command) and deassert both gnt_o.
REQ-015 SHALL, in IF_WAIT, forward mem_rvalid_i/mem_rdata_i to if_rvalid_o/if_rdata_o and return to IDLE in the cycle mem_rvalid_i=1.
REQ-016 SHALL, in LSU_WAIT, forward mem_rvalid_i to lsu_rvalid_o (read) or mem_wvalid_i to lsu_wdone_o (write) per the latched we, returning to IDLE on that valid.
REQ-017 SHALL keep response outputs of the non-owning requester at 0; rdata outputs SHALL be 0 when not valid.
REQ-018 SHALL, under fixed priority, grant LSU over fetch when both request in the same IDLE cycle.
REQ-019 SHALL allow back-to-back grants: request accepted in the IDLE cycle following a response, giving one transaction per 2 cycles.
REQ-020 SHALL ignore mem_rvalid_i/mem_wvalid_i arriving in IDLE (no response output, no state change).
REQ-021 SHALL require requesters to hold req/addr/we/wdata stable until gnt_o; values after gnt_o are don't-care.

Reset
REQ-022 SHALL, on rst assertion (asynchronous, any state, including mid-transaction), enter IDLE, clear latched we and priority pointer, and drop the in-flight response.
REQ-023 SHALL hold all outputs 0 while rst=1, including mem_ce_o=0.

Configuration
REQ-024 SHALL, with YSYX_22050058_ARB_RR_EN defined, use round-robin: a 1-bit last-grant register gives priority to the requester not granted last; reset value favours LSU.
REQ-025 SHALL, without YSYX_22050058_ARB_RR_EN, use the fixed LSU-first priority of REQ-018 and contain no last-grant register.

Structure
REQ-026 SHALL place FSM state encodings (2-bit localparams) and the read/write mask constants in the shared ysyx_22050058_define header.
REQ-027 SHALL contain one sub-module, ysyx_22050058_arb_pick, the combinational 2-way priority/round-robin selector.

Verification
REQ-028 Only if_req_i=1, addr 0x80000000; mem_rdata_i=0x00000013 next cycle -> if_gnt_o cycle 0, if_rvalid_o=1 with 0x13 cycle 1, IDLE cycle 2.
REQ-029 Both requesting in the same cycle, fixed priority -> lsu_gnt_o first; if_gnt_o two cycles later.
REQ-030 RR enabled, both requesting continuously for 8 cycles -> grants alternate LSU, IF, LSU, IF at cycles 0, 2, 4, 6.
REQ-031 LSU write we=0x0F, addr 0x80001000, wdata 0xDEADBEEF -> mem_we_o=0x0F that cycle; lsu_wdone_o=1 on mem_wvalid_i next cycle; lsu_rvalid_o stays 0.
REQ-032 rst pulsed asynchronously during IF_WAIT -> immediate IDLE, all outputs 0, later mem_rvalid_i produces no if_rvalid_o.
REQ-033 Stray mem_rvalid_i=1 in IDLE with no requests -> no rvalid outputs, state remains IDLE.
